// File: rtl/download_pkg.sv
// Shared types and constants for the HPS download -> DDR3 writer.
package download_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  localparam int unsigned LANES      = 4;
  localparam int unsigned WORD_BYTES = 8;

  // One 64-bit DDR word; addr is a word (not byte) address, zero-extended.
  typedef struct packed {
    logic [31:0]             addr;
    logic [WORD_BYTES-1:0]   mask;
    logic [WORD_BYTES*8-1:0] data;
  } ddr_word_t;

endpackage

// File: rtl/word_assembler.sv
// Packs 16-bit download words into one 64-bit assembly word with byte mask.
// Reports lane-3 (full) and word-address change (addr_mismatch); out_word is
// the word that leaves the assembler when the top decides to move it.
module word_assembler
  import download_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 25
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           dout,
  output logic                  asm_valid,
  output logic                  full,
  output logic                  addr_mismatch,
  output ddr_word_t             out_word
);

  localparam int unsigned WA_WIDTH = ADDR_WIDTH - 3;

  logic [$clog2(LANES)-1:0] lane;
  logic [WA_WIDTH-1:0]      word_addr;
  logic                     unused_addr_bit;

  logic [WORD_BYTES*8-1:0]  asm_data, asm_data_nx, merged_data;
  logic [WORD_BYTES-1:0]    asm_mask, asm_mask_nx, merged_mask;
  logic [WA_WIDTH-1:0]      asm_addr, asm_addr_nx;
  logic                     asm_valid_nx;

  assign lane            = addr[2:1];
  assign word_addr       = addr[ADDR_WIDTH-1:3];
  assign unused_addr_bit = addr[0];
  assign addr_mismatch   = asm_valid && (word_addr != asm_addr);
  assign full            = (lane == 2'd3);

  // Merge the incoming lane into the current word, or into an empty word on a jump
  always_comb begin
    merged_data = (asm_valid && !addr_mismatch) ? asm_data : '0;
    merged_mask = (asm_valid && !addr_mismatch) ? asm_mask : '0;
    merged_data[{lane, 4'b0000} +: 16] = dout;
    merged_mask = merged_mask | (WORD_BYTES'(2'b11) << {lane, 1'b0});
  end

  // Outgoing word: the merged word on lane-3 completion, otherwise the held word
  always_comb begin
    out_word = '0;
    if (wr && !addr_mismatch) begin
      out_word.addr = 32'(word_addr);
      out_word.mask = merged_mask;
      out_word.data = merged_data;
    end else begin
      out_word.addr = 32'(asm_addr);
      out_word.mask = asm_mask;
      out_word.data = asm_data;
    end
  end

  // Next assembly contents; a jump that lands on lane 3 keeps that lane held
  // because the old word already occupies the single pending slot
  always_comb begin
    asm_data_nx  = asm_data;
    asm_mask_nx  = asm_mask;
    asm_addr_nx  = asm_addr;
    asm_valid_nx = asm_valid;
    if (clear) begin
      asm_data_nx  = '0;
      asm_mask_nx  = '0;
      asm_addr_nx  = '0;
      asm_valid_nx = 1'b0;
    end else if (wr) begin
      if (full && !addr_mismatch) begin
        asm_data_nx  = '0;
        asm_mask_nx  = '0;
        asm_addr_nx  = '0;
        asm_valid_nx = 1'b0;
      end else begin
        asm_data_nx  = merged_data;
        asm_mask_nx  = merged_mask;
        asm_addr_nx  = word_addr;
        asm_valid_nx = 1'b1;
      end
    end else if (flush && asm_valid) begin
      asm_data_nx  = '0;
      asm_mask_nx  = '0;
      asm_addr_nx  = '0;
      asm_valid_nx = 1'b0;
    end
  end

  // Assembly register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      asm_data  <= '0;
      asm_mask  <= '0;
      asm_addr  <= '0;
      asm_valid <= 1'b0;
    end else begin
      asm_data  <= asm_data_nx;
      asm_mask  <= asm_mask_nx;
      asm_addr  <= asm_addr_nx;
      asm_valid <= asm_valid_nx;
    end
  end

endmodule

// File: rtl/download_ddr_writer.sv
// HPS ROM download responder: packs ioctl words into 64-bit DDR3 writes.
// Optional feature macro: DOWNLOAD_CHECKSUM_EN (16-bit running sum on checksum).
module download_ddr_writer
  import download_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH = 25
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  download_cs,
  input  logic                  download_wr,
  input  logic [ADDR_WIDTH-1:0] download_addr,
  input  logic [15:0]           download_dout,
  output logic                  download_wait,
  output logic                  download_done,
  output logic [15:0]           checksum,
  output logic                  ddr_wr,
  output logic [31:0]           ddr_addr,
  output logic [7:0]            ddr_mask,
  output logic [63:0]           ddr_din,
  output logic [7:0]            ddr_burstLength,
  input  logic                  ddr_waitReq
);

  state_t    state, state_nx;
  logic      cs_q;
  logic      clear, done;
  logic      wr_acc, flush, load;
  logic      asm_valid, full, addr_mismatch;
  ddr_word_t out_word, pend;
  logic      pend_valid;

  // Strobes are only taken in ACTIVE with wait low; anything else is dropped
  assign wr_acc = download_wr && !download_wait && (state == ACTIVE);
  assign flush  = (state == DRAIN) && asm_valid && !pend_valid;
  assign load   = (wr_acc && (full || addr_mismatch)) || flush;

  word_assembler #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_asm (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (clear),
    .wr            (wr_acc),
    .flush         (flush),
    .addr          (download_addr),
    .dout          (download_dout),
    .asm_valid     (asm_valid),
    .full          (full),
    .addr_mismatch (addr_mismatch),
    .out_word      (out_word)
  );

  // State register and download_cs edge history
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cs_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cs_q  <= download_cs;
    end
  end

  // Next state, assembly/checksum clear and done pulse
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (download_cs && !cs_q) begin
          state_nx = ACTIVE;
          clear    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!download_cs) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!asm_valid && !pend_valid) begin
          done = 1'b1;
          if (download_cs) begin
            state_nx = ACTIVE;
            clear    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pending word toward DDR; only loaded while empty, since wait blocks strobes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend       <= out_word;
      pend_valid <= 1'b1;
    end else if (pend_valid && !ddr_waitReq) begin
      pend_valid <= 1'b0;
    end
  end

  assign download_wait   = pend_valid || (state == DRAIN);
  assign download_done   = done;
  assign ddr_wr          = pend_valid;
  assign ddr_addr        = pend_valid ? (BASE_ADDR + (pend.addr << 3)) : '0;
  assign ddr_mask        = pend_valid ? pend.mask : '0;
  assign ddr_din         = pend_valid ? pend.data : '0;
  assign ddr_burstLength = 8'd1;

`ifdef DOWNLOAD_CHECKSUM_EN
  logic [15:0] sum;

  // Running mod-2^16 sum of accepted words, frozen once DRAIN is entered
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (wr_acc) begin
      sum <= sum + download_dout;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_download_ddr_writer.sv
// Self-checking bench for download_ddr_writer: a word-packing model predicts
// every DDR write; a negedge monitor compares each accepted write against it.
module tb_download_ddr_writer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        download_cs;
  logic        download_wr;
  logic [24:0] download_addr;
  logic [15:0] download_dout;
  logic        download_wait;
  logic        download_done;
  logic [15:0] checksum;
  logic        ddr_wr;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_mask;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_burstLength;
  logic        ddr_waitReq;

  always #5 clock = ~clock;

  download_ddr_writer #(
    .BASE_ADDR  (32'h3000_0000),
    .ADDR_WIDTH (25)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .download_cs     (download_cs),
    .download_wr     (download_wr),
    .download_addr   (download_addr),
    .download_dout   (download_dout),
    .download_wait   (download_wait),
    .download_done   (download_done),
    .checksum        (checksum),
    .ddr_wr          (ddr_wr),
    .ddr_addr        (ddr_addr),
    .ddr_mask        (ddr_mask),
    .ddr_din         (ddr_din),
    .ddr_burstLength (ddr_burstLength),
    .ddr_waitReq     (ddr_waitReq)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  // ---------------- model: byte-lane packing of the download stream
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_open = 0;
  int unsigned m_word = 0;
  logic [63:0] m_data = '0;
  logic [7:0]  m_mask = '0;
  logic [15:0] m_sum  = '0;

  function automatic void model_flush();
    exp_t e;
    if (m_open) begin
      e.addr = BASE + m_word * 8;
      e.mask = m_mask;
      e.data = m_data;
      exp_q.push_back(e);
    end
    m_open = 0;
  endfunction

  function automatic void model_write(input logic [24:0] a, input logic [15:0] d);
    int unsigned w;
    int unsigned lane;
    w    = a / 8;
    lane = (a / 2) % 4;
    if (m_open && w != m_word) model_flush();
    if (!m_open) begin
      m_open = 1;
      m_word = w;
      m_mask = '0;
      m_data = '0;
    end
    m_data[lane*16 +: 16] = d;
    m_mask[lane*2 +: 2]   = 2'b11;
    m_sum                 = m_sum + d;
    if (lane == 3) model_flush();
  endfunction

  function automatic logic [15:0] exp_sum();
`ifdef DOWNLOAD_CHECKSUM_EN
    return m_sum;
`else
    return 16'h0000;
`endif
  endfunction

  // ---------------- monitor
  logic        mon_en    = 1'b0;
  int          acc_count = 0;
  int          acc_cyc   = -100;
  int          done_count = 0;
  int          done_cyc  = -100;
  logic [31:0] last_addr = '0;
  logic [7:0]  last_mask = '0;
  logic [63:0] last_din  = '0;
  logic        stall_q   = 1'b0;
  logic [31:0] h_addr    = '0;
  logic [7:0]  h_mask    = '0;
  logic [63:0] h_din     = '0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mon_en) begin
      if (ddr_wr) begin
        check("wait_while_wr", download_wait, 1);
        check("addr_align", ddr_addr[2:0], 0);
        check("burst_len", ddr_burstLength, 1);
      end
      if (stall_q && ddr_wr) begin
        check("stall_addr", ddr_addr, h_addr);
        check("stall_mask", ddr_mask, h_mask);
        check("stall_din", ddr_din, h_din);
      end
      stall_q = ddr_wr && ddr_waitReq;
      h_addr  = ddr_addr;
      h_mask  = ddr_mask;
      h_din   = ddr_din;
      if (ddr_wr && !ddr_waitReq) begin
        exp_t e;
        acc_count++;
        acc_cyc   = cyc;
        last_addr = ddr_addr;
        last_mask = ddr_mask;
        last_din  = ddr_din;
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", ddr_addr, e.addr);
          check("wr_mask", ddr_mask, e.mask);
          check("wr_din", ddr_din, e.data);
        end
      end
      if (download_done) begin
        done_count++;
        done_cyc = cyc;
        check("done_all_drained", exp_q.size(), 0);
        check("checksum_at_done", checksum, exp_sum());
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dl();
    download_cs = 1'b1;
    m_sum  = '0;
    m_open = 0;
    tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [15:0] d);
    int n = 0;
    while (download_wait && n < 50) begin
      tick();
      n++;
    end
    if (download_wait) begin
      check("wait_timeout", download_wait, 0);
    end else begin
      download_wr   = 1'b1;
      download_addr = a;
      download_dout = d;
      model_write(a, d);
      tick();
      download_wr = 1'b0;
    end
  endtask

  task automatic end_dl(output int c0);
    int d0;
    int n = 0;
    download_cs = 1'b0;
    model_flush();
    c0 = cyc;
    d0 = done_count;
    while (done_count == d0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("done_single_pulse", done_count - d0, 1);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_count < target && n < 50) begin
      tick();
      n++;
    end
    check("accept_seen", acc_count >= target, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ddr_wr"}, ddr_wr, 0);
    check({tag, "_wait"}, download_wait, 0);
    check({tag, "_done"}, download_done, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_ddr_addr"}, ddr_addr, 0);
    check({tag, "_ddr_mask"}, ddr_mask, 0);
    check({tag, "_ddr_din"}, ddr_din, 0);
    check({tag, "_burst"}, ddr_burstLength, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int c0;
    int a0;
    reset_n       = 1'b0;
    download_cs   = 1'b0;
    download_wr   = 1'b0;
    download_addr = '0;
    download_dout = '0;
    ddr_waitReq   = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Full word, no stall
    start_dl();
    a0 = acc_count;
    strobe(25'h0, 16'h1111);
    strobe(25'h2, 16'h2222);
    strobe(25'h4, 16'h3333);
    strobe(25'h6, 16'h4444);
    check("t1_lat_ddr_wr", ddr_wr, 1);
    check("t1_lat_wait", download_wait, 1);
    wait_acc(a0 + 1);
    check("t1_addr", last_addr, 32'h3000_0000);
    check("t1_mask", last_mask, 8'hFF);
    check("t1_din", last_din, 64'h4444_3333_2222_1111);
    end_dl(c0);
    check("t1_done_lat", done_cyc - c0, 1);
    check("t1_writes", acc_count - a0, 1);

    // Partial word drained at cs fall
    start_dl();
    a0 = acc_count;
    strobe(25'h10, 16'hAAAA);
    strobe(25'h12, 16'hBBBB);
    end_dl(c0);
    check("t2_writes", acc_count - a0, 1);
    check("t2_addr", last_addr, 32'h3000_0010);
    check("t2_mask", last_mask, 8'h0F);
    check("t2_din", last_din, 64'h0000_0000_BBBB_AAAA);
    check("t2_done_after_acc", done_cyc - acc_cyc, 1);

    // DDR stall for 5 cycles
    start_dl();
    a0 = acc_count;
    ddr_waitReq = 1'b1;
    strobe(25'h40, 16'hC001);
    strobe(25'h42, 16'hC002);
    strobe(25'h44, 16'hC003);
    strobe(25'h46, 16'hC004);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_wr", ddr_wr, 1);
      check("t3_stall_wait", download_wait, 1);
      tick();
    end
    ddr_waitReq = 1'b0;
    wait_acc(a0 + 1);
    check("t3_addr", last_addr, 32'h3000_0040);
    check("t3_din", last_din, 64'hC004_C003_C002_C001);
    end_dl(c0);

    // Word-address jump
    start_dl();
    a0 = acc_count;
    strobe(25'h00, 16'h5555);
    strobe(25'h20, 16'h6666);
    end_dl(c0);
    check("t4_writes", acc_count - a0, 2);
    check("t4_addr", last_addr, 32'h3000_0020);
    check("t4_mask", last_mask, 8'h03);
    check("t4_din", last_din, 64'h0000_0000_0000_6666);

    // Reset while a write is stalled, then a clean download
    start_dl();
    ddr_waitReq = 1'b1;
    strobe(25'h0, 16'h0001);
    strobe(25'h2, 16'h0002);
    strobe(25'h4, 16'h0003);
    strobe(25'h6, 16'h0004);
    check("t5_pre_ddr_wr", ddr_wr, 1);
    download_cs = 1'b0;
    reset_n     = 1'b0;
    tick();
    check_outputs_zero("t5_rst");
    exp_q.delete();
    m_open      = 0;
    ddr_waitReq = 1'b0;
    reset_n     = 1'b1;
    tick();
    start_dl();
    a0 = acc_count;
    strobe(25'h8, 16'h0A0A);
    strobe(25'hA, 16'h0B0B);
    strobe(25'hC, 16'h0C0C);
    strobe(25'hE, 16'h0D0D);
    end_dl(c0);
    check("t5_writes", acc_count - a0, 1);
    check("t5_addr", last_addr, 32'h3000_0008);
    check("t5_mask", last_mask, 8'hFF);
    check("t5_din", last_din, 64'h0D0D_0C0C_0B0B_0A0A);

    // Checksum wrap
    start_dl();
    strobe(25'h0, 16'hFFFF);
    strobe(25'h2, 16'h0003);
    end_dl(c0);
`ifdef DOWNLOAD_CHECKSUM_EN
    check("t6_checksum", checksum, 16'h0002);
`else
    check("t6_checksum", checksum, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
